shapool_host_ctrl: RTL and testbench

Host-side SPI controller for a chain of shapool devices, built on a bridge FPGA. It drives each device's two SPI ports: the global job bus (sck0/sdi0/cs0_n, broadcast) and the daisy chain (sck1/sdi1/sdo1/cs1_n). It also watches the shared open-drain `ready_n` line. One `start` runs the full job: load per-device config, broadcast the job, wait for a hit or timeout, then read the result chain back.

---
 rtl/shapool_host_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_shapool_host_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shapool_host_ctrl.sv
// Host-side SPI sequencer for a shapool chain: daisy config load, broadcast job load,
// wait for the wired-OR ready line (or time out), then daisy read-back of the results.
module shapool_host_ctrl #(
  parameter int N_DEVICES           = 2,
  parameter int DEVICE_CONFIG_WIDTH = 8,
  parameter int JOB_CONFIG_WIDTH    = 360,
  parameter int RESULT_DATA_WIDTH   = 32,
  parameter int CLK_DIV             = 4,
  parameter int TIMEOUT_CYCLES      = 1 << 24
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       start,
  input  logic                                       abort,
  input  logic [N_DEVICES*DEVICE_CONFIG_WIDTH-1:0]   device_config,
  input  logic [JOB_CONFIG_WIDTH-1:0]                job_config,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       found,
  output logic [N_DEVICES*RESULT_DATA_WIDTH-1:0]     result_data,
  output logic                                       sck0_out,
  output logic                                       sdi0_out,
  output logic                                       cs0_n_out,
  output logic                                       sck1_out,
  output logic                                       sdo1_out,
  output logic                                       cs1_n_out,
  input  logic                                       sdi1_in,
  input  logic                                       ready_n_in,
  output logic [2:0]                                 state_o
);

  localparam int DEV_W = N_DEVICES * DEVICE_CONFIG_WIDTH;
  localparam int JOB_W = JOB_CONFIG_WIDTH;
  localparam int RES_W = N_DEVICES * RESULT_DATA_WIDTH;
  localparam int MAX_W = (DEV_W > JOB_W) ? ((DEV_W > RES_W) ? DEV_W : RES_W)
                                         : ((JOB_W > RES_W) ? JOB_W : RES_W);
  localparam int BIT_W = $clog2(MAX_W + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] DEV_TOP  = BIT_W'(DEV_W - 1);
  localparam logic [BIT_W-1:0] JOB_TOP  = BIT_W'(JOB_W - 1);
  localparam logic [BIT_W-1:0] RES_TOP  = BIT_W'(RES_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_DEV, S_GAP_DEV, S_LOAD_JOB, S_RUN, S_GAP_RUN, S_READ, S_FINISH
  } state_t;
  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_TAIL, PH_END} phase_t;

  state_t            state_q;
  phase_t            phase_q;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic [RUN_W-1:0]  run_q;
  logic [DEV_W-1:0]  dev_q;
  logic [JOB_W-1:0]  job_q;
  logic [RES_W-1:0]  result_q;
  logic              found_q, done_q;
  logic              sck0_q, sdi0_q, cs0_n_q, sck1_q, sdo1_q, cs1_n_q;
  logic              rdy_meta_q, rdy_sync_q;

  // Handshake: start is a one-cycle request taken only in IDLE; done is a one-cycle
  // completion pulse, and found/result_data are valid from it until the next start.
  logic div_last, bit_last, in_xfer, sck_rise, sck_fall, xfer_end;
  assign div_last = (div_q == DIV_LAST);
  assign bit_last = (bit_q == '0);
  assign in_xfer  = ((state_q == S_LOAD_DEV) || (state_q == S_LOAD_JOB) ||
                     (state_q == S_READ)) && (phase_q != PH_END);
  assign sck_rise = in_xfer && (phase_q == PH_LOW)  && div_last;
  assign sck_fall = in_xfer && (phase_q == PH_HIGH) && div_last;
  assign xfer_end = in_xfer && (phase_q == PH_TAIL) && div_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_LOW;
      div_q      <= '0;
      bit_q      <= '0;
      run_q      <= '0;
      dev_q      <= '0;
      job_q      <= '0;
      result_q   <= '0;
      found_q    <= 1'b0;
      done_q     <= 1'b0;
      sck0_q     <= 1'b0;
      sdi0_q     <= 1'b0;
      cs0_n_q    <= 1'b1;
      sck1_q     <= 1'b0;
      sdo1_q     <= 1'b0;
      cs1_n_q    <= 1'b1;
      rdy_meta_q <= 1'b1;
      rdy_sync_q <= 1'b1;
    end else begin
      rdy_meta_q <= ready_n_in;
      rdy_sync_q <= rdy_meta_q;
      done_q     <= 1'b0;
      // Shared bit timer: LOW and HIGH half-bits, then one trailing LOW before CS lifts.
      if (in_xfer) begin
        div_q <= div_last ? '0 : div_q + 1'b1;
        if (sck_rise) phase_q <= PH_HIGH;
        if (sck_fall) begin
          phase_q <= bit_last ? PH_TAIL : PH_LOW;
          if (!bit_last) bit_q <= bit_q - 1'b1;
        end
      end
      if (abort) begin
        state_q <= S_IDLE;
        phase_q <= PH_LOW;
        div_q   <= '0;
        bit_q   <= '0;
        run_q   <= '0;
        sck0_q  <= 1'b0;
        sdi0_q  <= 1'b0;
        cs0_n_q <= 1'b1;
        sck1_q  <= 1'b0;
        sdo1_q  <= 1'b0;
        cs1_n_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            state_q  <= S_LOAD_DEV;
            dev_q    <= device_config;
            job_q    <= job_config;
            found_q  <= 1'b0;
            result_q <= '0;
            cs1_n_q  <= 1'b0;
            sdo1_q   <= device_config[DEV_W-1];
            bit_q    <= DEV_TOP;
            div_q    <= '0;
            phase_q  <= PH_LOW;
          end
          S_LOAD_DEV: begin
            if (sck_rise) sck1_q <= 1'b1;
            if (sck_fall) begin
              sck1_q <= 1'b0;
              sdo1_q <= bit_last ? 1'b0 : dev_q[DEV_W-2];
              dev_q  <= {dev_q[DEV_W-2:0], 1'b0};
            end
            if (xfer_end) begin
              cs1_n_q <= 1'b1;
              state_q <= S_GAP_DEV;
            end
          end
          S_GAP_DEV: if (div_last) begin
            div_q   <= '0;
            state_q <= S_LOAD_JOB;
            cs0_n_q <= 1'b0;
            sdi0_q  <= job_q[JOB_W-1];
            bit_q   <= JOB_TOP;
            phase_q <= PH_LOW;
          end else begin
            div_q <= div_q + 1'b1;
          end
          S_LOAD_JOB: begin
            if (sck_rise) sck0_q <= 1'b1;
            if (sck_fall) begin
              sck0_q <= 1'b0;
              sdi0_q <= bit_last ? 1'b0 : job_q[JOB_W-2];
              job_q  <= {job_q[JOB_W-2:0], 1'b0};
            end
            // Devices start hashing on this CS0 rising edge.
            if (xfer_end) begin
              cs0_n_q <= 1'b1;
              state_q <= S_RUN;
              run_q   <= '0;
            end
          end
          S_RUN: if (!rdy_sync_q) begin
            state_q <= S_GAP_RUN;
            div_q   <= '0;
          end else if (run_q == RUN_LAST) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else begin
            run_q <= run_q + 1'b1;
          end
          S_GAP_RUN: if (div_last) begin
            div_q   <= '0;
            state_q <= S_READ;
            cs1_n_q <= 1'b0;
            sdo1_q  <= 1'b0;
            bit_q   <= RES_TOP;
            phase_q <= PH_LOW;
          end else begin
            div_q <= div_q + 1'b1;
          end
          S_READ: begin
            if (sck_rise) begin
              sck1_q   <= 1'b1;
              result_q <= {result_q[RES_W-2:0], sdi1_in};
            end
            if (sck_fall) sck1_q <= 1'b0;
            if (xfer_end) begin
              cs1_n_q <= 1'b1;
              found_q <= 1'b1;
              phase_q <= PH_END;
            end
            // One cycle with CS1 high before done.
            if (phase_q == PH_END) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
              phase_q <= PH_LOW;
            end
          end
          S_FINISH: state_q <= S_IDLE;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign found       = found_q;
  assign result_data = result_q;
  assign sck0_out    = sck0_q;
  assign sdi0_out    = sdi0_q;
  assign cs0_n_out   = cs0_n_q;
  assign sck1_out    = sck1_q;
  assign sdo1_out    = sdo1_q;
  assign cs1_n_out   = cs1_n_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_shapool_host_ctrl.sv
// Directed bench for shapool_host_ctrl: reset/idle, full job with a device model,
// timeout (second instance with a short timeout), abort, restart-while-busy, async reset.
module tb_shapool_host_ctrl;
  localparam int ND   = 2;
  localparam int DCW  = 8;
  localparam int JW   = 360;
  localparam int RW   = 32;
  localparam int CD   = 2;
  localparam int DW   = ND * DCW;
  localparam int RESW = ND * RW;

  logic            clk = 1'b0;
  logic            reset_n, start, abort, sdi1_in, ready_n_in;
  logic [DW-1:0]   device_config;
  logic [JW-1:0]   job_config;
  logic            busy, done, found, sck0, sdi0, cs0_n, sck1, sdo1, cs1_n;
  logic [RESW-1:0] result_data;
  logic [2:0]      state;
  logic            busy2, done2, found2, sck02, sdi02, cs0_n2, sck12, sdo12, cs1_n2;
  logic [RESW-1:0] result_data2;
  logic [2:0]      state2;
  logic            ready_n2 = 1'b1;
  logic            sdi1_2   = 1'b0;

  shapool_host_ctrl #(.N_DEVICES(ND), .DEVICE_CONFIG_WIDTH(DCW), .JOB_CONFIG_WIDTH(JW),
    .RESULT_DATA_WIDTH(RW), .CLK_DIV(CD), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .device_config(device_config), .job_config(job_config),
    .busy(busy), .done(done), .found(found), .result_data(result_data),
    .sck0_out(sck0), .sdi0_out(sdi0), .cs0_n_out(cs0_n),
    .sck1_out(sck1), .sdo1_out(sdo1), .cs1_n_out(cs1_n),
    .sdi1_in(sdi1_in), .ready_n_in(ready_n_in), .state_o(state));

  shapool_host_ctrl #(.N_DEVICES(ND), .DEVICE_CONFIG_WIDTH(DCW), .JOB_CONFIG_WIDTH(JW),
    .RESULT_DATA_WIDTH(RW), .CLK_DIV(CD), .TIMEOUT_CYCLES(50)) dut_to (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .device_config(device_config), .job_config(job_config),
    .busy(busy2), .done(done2), .found(found2), .result_data(result_data2),
    .sck0_out(sck02), .sdi0_out(sdi02), .cs0_n_out(cs0_n2),
    .sck1_out(sck12), .sdo1_out(sdo12), .cs1_n_out(cs1_n2),
    .sdi1_in(sdi1_2), .ready_n_in(ready_n2), .state_o(state2));

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Observations collected by run_job
  int t, n_ep, done_at, done_w, found_at_done, cs0_fall, cs0_rise, cs0_low;
  int sck0_rises, rd_rises, both_low, sdo1_rd_nz, ready_at, abort_t, post_busy;
  int to_rise, to_done, to_ep, to_found;
  int cs1_fall[2], cs1_rise[2], cs1_low[2];
  int ab_busy, ab_cs0, ab_cs1, ab_sck0, ab_sck1, ab_sdi0, ab_sdo1;
  logic [DW-1:0] dev_bits;
  logic          first_sdi0, last_sdi0, finished;
  logic [63:0]   rd_word;

  task automatic run_job(input int ready_delay, input int restart_at, input int abort_after,
                         input int budget);
    int cur_ep, rd_idx;
    logic p_cs1, p_cs0, p_sck1, p_sck0, p_cs0_2, p_cs1_2;
    n_ep = 0; done_at = -1; done_w = 0; found_at_done = -1; cs0_fall = -1; cs0_rise = -1;
    cs0_low = 0; sck0_rises = 0; rd_rises = 0; both_low = 0; sdo1_rd_nz = 0;
    ready_at = -1; abort_t = -1; post_busy = 0; to_rise = -1; to_done = -1; to_ep = 0;
    to_found = -1; rd_idx = -1; dev_bits = '0; first_sdi0 = 1'b0; last_sdi0 = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 2; i++) begin cs1_fall[i] = -1; cs1_rise[i] = -1; cs1_low[i] = 0; end
    p_cs1 = cs1_n; p_cs0 = cs0_n; p_sck1 = sck1; p_sck0 = sck0;
    p_cs0_2 = cs0_n2; p_cs1_2 = cs1_n2;
    t = 0;
    start = 1'b1;
    @(negedge clk); t = 1;
    while (!finished && t < budget) begin
      start = 1'b0;
      abort = 1'b0;
      if (t == 2) begin
        device_config = '1;
        job_config    = '0;
      end
      if (p_cs1 && !cs1_n) begin
        n_ep++;
        if (n_ep <= 2) cs1_fall[n_ep-1] = t;
        if (n_ep == 2) begin sdi1_in = rd_word[63]; rd_idx = 62; end
      end
      cur_ep = n_ep - 1;
      if (!p_cs1 && cs1_n && cur_ep >= 0 && cur_ep < 2) cs1_rise[cur_ep] = t;
      if (!cs1_n && cur_ep >= 0 && cur_ep < 2) cs1_low[cur_ep]++;
      if (!p_sck1 && sck1) begin
        if (cur_ep == 0) dev_bits = {dev_bits[DW-2:0], sdo1};
        else rd_rises++;
      end
      if (p_sck1 && !sck1 && cur_ep == 1 && rd_idx >= 0) begin
        sdi1_in = rd_word[rd_idx];
        rd_idx--;
      end
      if (!cs1_n && cur_ep == 1 && sdo1) sdo1_rd_nz++;
      if (!cs0_n) begin
        cs0_low++;
        if (p_cs0 && cs0_fall < 0) cs0_fall = t;
      end
      if (!p_cs0 && cs0_n && cs0_rise < 0) cs0_rise = t;
      if (!p_sck0 && sck0) begin
        sck0_rises++;
        if (sck0_rises == 1) first_sdi0 = sdi0;
        last_sdi0 = sdi0;
      end
      if (!cs0_n && !cs1_n) both_low++;
      if (done) begin
        if (done_at < 0) begin done_at = t; found_at_done = int'(found); end
        done_w++;
      end
      if (!p_cs0_2 && cs0_n2 && to_rise < 0) to_rise = t;
      if (p_cs1_2 && !cs1_n2) to_ep++;
      if (done2 && to_done < 0) begin to_done = t; to_found = int'(found2); end
      // Device model: ready drops ready_delay cycles into RUN
      if (ready_delay >= 0 && cs0_rise >= 0 && t == cs0_rise + ready_delay) begin
        ready_n_in = 1'b0;
        ready_at = t;
      end
      if (restart_at >= 0 && t == restart_at) start = 1'b1;
      if (abort_after >= 0 && cs0_fall >= 0 && t == cs0_fall + abort_after) begin
        abort = 1'b1;
        start = 1'b1;
        abort_t = t;
      end
      if (abort_t >= 0 && t == abort_t + 1) begin
        ab_busy = int'(busy); ab_cs0 = int'(cs0_n); ab_cs1 = int'(cs1_n);
        ab_sck0 = int'(sck0); ab_sck1 = int'(sck1); ab_sdi0 = int'(sdi0); ab_sdo1 = int'(sdo1);
      end
      if (abort_t >= 0 && t > abort_t && busy) post_busy++;
      finished = (done_at >= 0 && to_done >= 0 && t > done_at + 2) ||
                 (abort_t >= 0 && t >= abort_t + 20);
      p_cs1 = cs1_n; p_cs0 = cs0_n; p_sck1 = sck1; p_sck0 = sck0;
      p_cs0_2 = cs0_n2; p_cs1_2 = cs1_n2;
      @(negedge clk); t++;
    end
    start = 1'b0;
    abort = 1'b0;
    ready_n_in = 1'b1;
    sdi1_in = 1'b0;
    check("job_finished_in_budget", finished, 1);
  endtask

  int idle_act;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; sdi1_in = 1'b0; ready_n_in = 1'b1;
    device_config = '0; job_config = '0; rd_word = 64'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_result", result_data, 0);
    check("rst_sck0", sck0, 0);
    check("rst_sck1", sck1, 0);
    check("rst_cs0_n", cs0_n, 1);
    check("rst_cs1_n", cs1_n, 1);
    check("rst_sdi0", sdi0, 0);
    check("rst_sdo1", sdo1, 0);
    idle_act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sck0 || sck1 || !cs0_n || !cs1_n || busy || done || sdi0 || sdo1) idle_act++;
    end
    check("idle_activity", idle_act, 0);

    // Full job: config latched, then inputs scrambled at t=2
    device_config = 16'hA503;
    job_config    = {32'hC0FFEE11, 320'h0, 8'h01};
    rd_word       = 64'hDEADBEEF_00000042;
    run_job(100, -1, -1, 4000);
    check("start_to_cs1_low", cs1_fall[0], 1);
    check("load_cs1_low_cycles", cs1_low[0], 66);
    check("load_dev_bits", dev_bits, 16'hA503);
    check("gap_dev_to_job", cs0_fall - cs1_rise[0], CD);
    check("job_sck0_rises", sck0_rises, 360);
    check("job_first_bit", first_sdi0, 1);
    check("job_last_bit", last_sdi0, 1);
    check("job_cs0_low_cycles", cs0_low, 1442);
    check("cs_exclusive", both_low, 0);
    check("ready_to_read_cs1", cs1_fall[1] - ready_at, 5);
    check("read_cs1_low_cycles", cs1_low[1], 258);
    check("read_sck1_rises", rd_rises, 64);
    check("read_sdo1_zero", sdo1_rd_nz, 0);
    check("done_after_cs1_rise", done_at - cs1_rise[1], 1);
    check("done_width", done_w, 1);
    check("found_at_done", found_at_done, 1);
    check("result_data", result_data, 64'hDEADBEEF00000042);
    check("found_held", found, 1);
    check("busy_after_done", busy, 0);
    check("to_run_cycles", to_done - to_rise, 50);
    check("to_found", to_found, 0);
    check("to_no_read", to_ep, 1);
    check("to_result", result_data2, 0);

    // Restart while busy is ignored; abort (with start) mid job load
    repeat (5) @(negedge clk);
    device_config = 16'h3C96;
    job_config    = {JW{1'b1}};
    run_job(-1, 10, 100, 4000);
    check("ab_cs1_episodes", n_ep, 1);
    check("ab_load_cs1_low", cs1_low[0], 66);
    check("ab_load_bits", dev_bits, 16'h3C96);
    check("ab_busy", ab_busy, 0);
    check("ab_cs0_n", ab_cs0, 1);
    check("ab_cs1_n", ab_cs1, 1);
    check("ab_sck0", ab_sck0, 0);
    check("ab_sck1", ab_sck1, 0);
    check("ab_sdi0", ab_sdi0, 0);
    check("ab_sdo1", ab_sdo1, 0);
    check("ab_start_ignored", post_busy, 0);
    check("ab_no_done", done_w, 0);
    check("ab_found", found, 0);
    check("ab_result", result_data, 0);

    // Asynchronous reset in the middle of the config load
    device_config = 16'h5AA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_cs1_low", cs1_n, 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_cs1_n", cs1_n, 1);
    check("arst_sck1", sck1, 0);
    check("arst_sdo1", sdo1, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
